// File: rtl/fifo_controller_if.sv
// -----------------------------------------------------------------------------
// fifo_controller_if
// Bundles the FIFO user / register-file side signals of fifo_controller.
//
// Handshake semantics: a request is the level of wr_en / rd_en sampled at a
// rising clock edge. There is no back-pressure. The outcome of the request
// appears in the following cycle on wr_ack / wr_err / rd_ack / rd_err.
// wr_en and rd_en high together is a NO_OP. The register file captures
// wData at wAddr on any edge where we is high. rData is combinational from
// rAddr.
//
// master : FIFO user plus register file (drives requests and rData)
// slave  : fifo_controller
// -----------------------------------------------------------------------------
interface fifo_controller_if;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] din;
    logic [31:0] rData;
    logic        we;
    logic [2:0]  wAddr;
    logic [31:0] wData;
    logic [2:0]  rAddr;
    logic [31:0] dout;
    logic        full;
    logic        empty;
    logic        wr_ack;
    logic        wr_err;
    logic        rd_ack;
    logic        rd_err;
    logic [3:0]  data_count;

    modport master (
        output wr_en, rd_en, din, rData,
        input  we, wAddr, wData, rAddr, dout, full, empty,
        input  wr_ack, wr_err, rd_ack, rd_err, data_count
    );

    modport slave (
        input  wr_en, rd_en, din, rData,
        output we, wAddr, wData, rAddr, dout, full, empty,
        output wr_ack, wr_err, rd_ack, rd_err, data_count
    );
endinterface

// File: rtl/fifo_controller.sv
// -----------------------------------------------------------------------------
// fifo_controller
// Control block for an 8 x 32 FIFO whose storage is an external register
// file. It keeps the head and tail pointers and the occupancy count. It turns
// push/pop requests into register-file write strobes and addresses. It
// registers the popped word and reports status and per-request outcome flags.
//
// Ports:
//   clk          in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   bus          slave modport of fifo_controller_if (requests, register-file
//                signals, dout, status, ack/err flags, data_count)
//   o_dbg_state  out  current outcome-state encoding
// -----------------------------------------------------------------------------
module fifo_controller (
    input  logic             clk,
    input  logic             reset_n,
    fifo_controller_if.slave bus,
    output logic [2:0]       o_dbg_state
);

    typedef enum logic [2:0] {
        INIT     = 3'd0,
        NO_OP    = 3'd1,
        WRITE    = 3'd2,
        WR_ERROR = 3'd3,
        READ     = 3'd4,
        RD_ERROR = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [2:0]  r_head;
    logic [2:0]  r_tail;
    logic [3:0]  r_count;
    logic [31:0] r_dout;
    logic        w_full;
    logic        w_empty;

    assign w_full  = (r_count == 4'd8);
    assign w_empty = (r_count == 4'd0);

    // Decode this cycle's request against the current count. The outcome
    // state is both the action taken at the edge and the source of the
    // following cycle's ack/err flags.
    always_comb begin
        w_next_state = NO_OP;
        if (bus.wr_en && !bus.rd_en) begin
            w_next_state = w_full ? WR_ERROR : WRITE;
        end else if (bus.rd_en && !bus.wr_en) begin
            w_next_state = w_empty ? RD_ERROR : READ;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= INIT;
            r_head  <= 3'd0;
            r_tail  <= 3'd0;
            r_count <= 4'd0;
            r_dout  <= 32'd0;
        end else begin
            r_state <= w_next_state;
            case (w_next_state)
                WRITE: begin
                    r_tail  <= r_tail + 3'd1;
                    r_count <= r_count + 4'd1;
                end
                READ: begin
                    // rData already reflects the word at head (rAddr)
                    r_dout  <= bus.rData;
                    r_head  <= r_head + 3'd1;
                    r_count <= r_count - 4'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // The write strobe is gated by full, so a push to a full FIFO never
    // overwrites the entry at head.
    assign bus.we         = bus.wr_en & ~bus.rd_en & ~w_full;
    assign bus.wAddr      = r_tail;
    assign bus.wData      = bus.din;
    assign bus.rAddr      = r_head;
    assign bus.dout       = r_dout;
    assign bus.full       = w_full;
    assign bus.empty      = w_empty;
    assign bus.data_count = r_count;
    assign bus.wr_ack     = (r_state == WRITE);
    assign bus.wr_err     = (r_state == WR_ERROR);
    assign bus.rd_ack     = (r_state == READ);
    assign bus.rd_err     = (r_state == RD_ERROR);
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_fifo_controller.sv
// -----------------------------------------------------------------------------
// tb_fifo_controller
// Drives fifo_controller through directed and random push/pop traffic. A
// behavioural register file and a queue-based FIFO model sit in the bench.
// Expected outcome records go into exp_q, and a negedge monitor compares them.
// -----------------------------------------------------------------------------
module tb_fifo_controller;

    localparam int W = 40;   // {wr_ack, wr_err, rd_ack, rd_err, dout[31:0], count[3:0]}

    logic clk;
    logic reset_n;
    logic [2:0] dbg_state;

    fifo_controller_if bus();

    fifo_controller dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural register file ----------------
    logic [31:0] rf [8];
    initial for (int i = 0; i < 8; i++) rf[i] = 32'd0;
    always @(posedge clk) if (bus.we) rf[bus.wAddr] <= bus.wData;
    assign bus.rData = rf[bus.rAddr];

    // ---------------- reference model ----------------
    logic [31:0] model_q[$];
    logic [31:0] model_dout;
    int          wr_total;
    int          rd_total;
    logic [W-1:0] exp_q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            chk("wr_ack",     {31'd0, bus.wr_ack},   {31'd0, e[39]});
            chk("wr_err",     {31'd0, bus.wr_err},   {31'd0, e[38]});
            chk("rd_ack",     {31'd0, bus.rd_ack},   {31'd0, e[37]});
            chk("rd_err",     {31'd0, bus.rd_err},   {31'd0, e[36]});
            chk("dout",       bus.dout,              e[35:4]);
            chk("data_count", {28'd0, bus.data_count}, {28'd0, e[3:0]});
            chk("full",       {31'd0, bus.full},     {31'd0, (e[3:0] == 4'd8)});
            chk("empty",      {31'd0, bus.empty},    {31'd0, (e[3:0] == 4'd0)});
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1; returns at the next posedge+1.
    task automatic do_cycle(input logic w, input logic r, input logic [31:0] d);
        logic exp_we;
        logic wa, we_, ra, re;
        int   sz;
        bus.wr_en = w;
        bus.rd_en = r;
        bus.din   = d;
        #1;
        sz     = model_q.size();
        exp_we = w && !r && (sz < 8);
        chk("we",    {31'd0, bus.we}, {31'd0, exp_we});
        chk("wAddr", {29'd0, bus.wAddr}, 32'(wr_total % 8));
        chk("rAddr", {29'd0, bus.rAddr}, 32'(rd_total % 8));
        if (exp_we) chk("wData", bus.wData, d);
        wa = 1'b0; we_ = 1'b0; ra = 1'b0; re = 1'b0;
        if (w && !r) begin
            if (sz < 8) begin
                model_q.push_back(d);
                wr_total++;
                wa = 1'b1;
            end else begin
                we_ = 1'b1;
            end
        end else if (r && !w) begin
            if (sz > 0) begin
                model_dout = model_q.pop_front();
                rd_total++;
                ra = 1'b1;
            end else begin
                re = 1'b1;
            end
        end
        @(posedge clk);
        exp_q.push_back({wa, we_, ra, re, model_dout, 4'(model_q.size())});
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_empty"},  {31'd0, bus.empty},      32'd1);
        chk({tag, "_full"},   {31'd0, bus.full},       32'd0);
        chk({tag, "_count"},  {28'd0, bus.data_count}, 32'd0);
        chk({tag, "_dout"},   bus.dout,                32'd0);
        chk({tag, "_flags"},  {28'd0, bus.wr_ack, bus.wr_err, bus.rd_ack, bus.rd_err}, 32'd0);
        chk({tag, "_state"},  {29'd0, dbg_state},      32'd0);
        chk({tag, "_wAddr"},  {29'd0, bus.wAddr},      32'd0);
        chk({tag, "_rAddr"},  {29'd0, bus.rAddr},      32'd0);
    endtask

    // Asserted at posedge+1 (mid-cycle), released one edge later.
    task automatic do_reset();
        exp_q.delete();
        model_q.delete();
        model_dout = 32'd0;
        wr_total   = 0;
        rd_total   = 0;
        bus.wr_en  = 1'b0;
        bus.rd_en  = 1'b0;
        reset_n    = 1'b0;
        #1;
        check_reset_values("rst_async");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        check_reset_values("rst_release");
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset_n    = 1'b0;
        bus.wr_en  = 1'b0;
        bus.rd_en  = 1'b0;
        bus.din    = 32'd0;
        model_dout = 32'd0;
        wr_total   = 0;
        rd_total   = 0;
        @(posedge clk);
        #1;
        do_reset();

        // idle three cycles
        for (int i = 0; i < 3; i++) do_cycle(1'b0, 1'b0, 32'd0);

        // fill, overflow, drain, underflow
        for (int i = 1; i <= 8; i++) do_cycle(1'b1, 1'b0, 32'h11111111 * i);
        do_cycle(1'b1, 1'b0, 32'hDEADBEEF);
        for (int i = 0; i < 8; i++) do_cycle(1'b0, 1'b1, 32'd0);
        do_cycle(1'b0, 1'b1, 32'd0);

        // wrap-around
        for (int i = 0; i < 5; i++) do_cycle(1'b1, 1'b0, $urandom);
        for (int i = 0; i < 5; i++) do_cycle(1'b0, 1'b1, 32'd0);
        for (int i = 0; i < 6; i++) do_cycle(1'b1, 1'b0, $urandom);
        for (int i = 0; i < 6; i++) do_cycle(1'b0, 1'b1, 32'd0);

        // simultaneous push and pop
        for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b0, 32'hC0DE0000 + i);
        for (int i = 0; i < 2; i++) do_cycle(1'b1, 1'b1, 32'hBAD0BAD0);
        for (int i = 0; i < 3; i++) do_cycle(1'b0, 1'b1, 32'd0);

        // random traffic, write-biased then read-biased
        for (int i = 0; i < 400; i++) begin
            int wp;
            wp = (i < 200) ? 65 : 35;
            do_cycle(($urandom_range(0, 99) < wp), ($urandom_range(0, 99) < 50), $urandom);
        end

        // reset mid-burst
        for (int i = 1; i <= 4; i++) do_cycle(1'b1, 1'b0, 32'h01010101 * i);
        do_reset();
        do_cycle(1'b0, 1'b1, 32'd0);
        do_cycle(1'b1, 1'b0, 32'hA5A5A5A5);
        do_cycle(1'b0, 1'b1, 32'd0);
        do_cycle(1'b0, 1'b0, 32'd0);

        // let the monitor drain
        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_controller.md
# fifo_controller

Control block for an 8-entry × 32-bit synchronous FIFO built around the team's 8-entry × 32-bit register file. Converts push/pop requests into register-file write strobes and read/write addresses, and keeps head/tail pointers and occupancy count. Registers the popped word and reports full/empty status and per-request acknowledge/error flags. Sits between the FIFO user and the register file; the register file holds the storage.

## Interface
- Parameters: none. Depth is fixed at 8 and width at 32 to match the register file.
- clk  in  1  clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- wr_en  in  1  push request
- rd_en  in  1  pop request
- din  in  32  push data
- rData  in  32  register-file read data, combinational from rAddr
- we  out  1  register-file write enable
- wAddr  out  3  register-file write address (tail)
- wData  out  32  register-file write data
- rAddr  out  3  register-file read address (head)
- dout  out  32  last popped word (registered)
- full  out  1  count == 8
- empty  out  1  count == 0
- wr_ack, wr_err, rd_ack, rd_err  out  1 each  outcome of the previous cycle's request
- data_count  out  4  occupancy, 0..8

## Operation
- State: head[2:0], tail[2:0], count[3:0], dout[31:0], and a 3-bit outcome state with values INIT, NO_OP, WRITE, WR_ERROR, READ, RD_ERROR.
- Request decode for each cycle, using the current count:
  - wr_en & ~rd_en & count<8 → WRITE
  - wr_en & ~rd_en & count==8 → WR_ERROR
  - rd_en & ~wr_en & count>0 → READ
  - rd_en & ~wr_en & count==0 → RD_ERROR
  - Both high or both low → NO_OP
- Actions on the clock edge:
  - WRITE: tail ← tail+1 (mod 8, wraps 7→0), count+1
  - READ: dout ← rData, head ← head+1 (mod 8), count−1
  - WR_ERROR, RD_ERROR, NO_OP: pointers, count and dout unchanged
- Simultaneous push+pop is a defined NO_OP: no write, no pop, no ack, no error.
- Combinational outputs:
  - we = wr_en & ~rd_en & ~full
  - wAddr = tail
  - wData = din
  - rAddr = head
- Moore outputs, decoded from the outcome state:
  - wr_ack = (state==WRITE)
  - wr_err = (state==WR_ERROR)
  - rd_ack = (state==READ)
  - rd_err = (state==RD_ERROR)
- full, empty and data_count decode from the registered count.
- A push to a full FIFO never asserts we and never overwrites. A pop from an empty FIFO never moves head and never changes dout.

## Timing
- Reset (asynchronous, immediate):
  - head = tail = 0, count = 0, dout = 0, state = INIT
  - empty = 1, full = 0, all ack/err = 0, data_count = 0
  - This applies mid-operation as well: any in-flight request is discarded.
- Write latency:
  - we is asserted in the same cycle as wr_en. The register file captures the data at that edge.
  - wr_ack is high for the following cycle only, unless the next request is also a successful write.
- Read latency:
  - dout is valid one cycle after the rd_en cycle, aligned with rd_ack.
  - dout holds its value until the next successful READ.
- A word written at edge N can be popped by a request in cycle N+1, because count is already updated.
- full and empty change in the cycle after the edge that moves count.
- Back-to-back pushes or pops at one per cycle are allowed, with no bubbles.

## Test plan
- Reset then idle 3 cycles → empty=1, full=0, data_count=0, dout=0, all ack/err 0, we=0.
- Push 0x11111111..0x88888888 on 8 consecutive cycles:
  - wr_ack high for 8 cycles.
  - After the last push: full=1, data_count=8, tail=0 (wrapped).
  - A 9th push of 0xDEADBEEF → we=0 and wr_err=1 for one cycle; count stays 8.
- From full, pop 8 times → dout sequence 0x11111111..0x88888888, one cycle after each rd_en, rd_ack each cycle. Ends with empty=1.
  - A 9th pop → rd_err=1, dout stays 0x88888888.
- Wrap-around:
  - Push 5, pop 5, then push 6 (tail crosses 7→0), then pop 6.
  - Required: FIFO order preserved, data_count tracks 0..6.
- Simultaneous push and pop:
  - Push 3 words, then assert wr_en=rd_en=1 for 2 cycles → NO_OP, we=0, count stays 3, no ack/err.
  - Then pop 3 → original order returned.
- Reset asserted mid-burst (after 4 of 8 pushes), then released → all outputs at reset values immediately.
  - A subsequent pop → rd_err=1.
  - A subsequent push of 0xA5A5A5A5 followed by a pop → dout=0xA5A5A5A5.
